tetris_engine: RTL

//  Sequential, parametrised Tetris game core: holds the static board and falling piece, executes
//  one move command at a time through a collision-check FSM, locks pieces, clears full rows one per

---
 rtl/tetris_engine_pkg.sv | 57 +++++
 rtl/tetris_engine_collision_check.sv | 38 +++
 rtl/tetris_engine.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_engine_pkg.sv
// Shared types for the Tetris core: command codes, FSM states, piece masks and rotation helpers.
// A mask is 16 bits; bit r*4+c is mask[r][c], where row 0 is the top row and column 0 is the left.
package tetris_engine_pkg;

  typedef enum logic [2:0] {
    CmdCw    = 3'd0,
    CmdCcw   = 3'd1,
    CmdLeft  = 3'd2,
    CmdRight = 3'd3,
    CmdSoft  = 3'd4,
    CmdHard  = 3'd5,
    CmdStart = 3'd6,
    CmdNop   = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle, StReady, StCheck, StDrop, StLock, StClear, StSpawn, StOver
  } state_e;

  typedef logic [15:0] mask_t;

  // Piece order: 0 I, 1 L, 2 J, 3 Z, 4 S, 5 T, 6 O; index 7 falls back to I.
  function automatic mask_t piece_mask(input logic [2:0] sel);
    mask_t m;
    case (sel)
      3'd1:    m = 16'h02E0;
      3'd2:    m = 16'h0470;
      3'd3:    m = 16'h0630;
      3'd4:    m = 16'h0360;
      3'd5:    m = 16'h0270;
      3'd6:    m = 16'h0660;
      default: m = 16'h2222;
    endcase
    return m;
  endfunction

  function automatic mask_t rot_cw(input mask_t m);
    mask_t n;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        n[r*4+c] = m[(3-c)*4+r];
      end
    end
    return n;
  endfunction

  function automatic mask_t rot_ccw(input mask_t m);
    mask_t n;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        n[r*4+c] = m[c*4+(3-r)];
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/tetris_engine_collision_check.sv
// Combinational collision test of a 4x4 piece mask placed at (pos_x, pos_y) against the board.
// Cells sit at (pos_x+c, pos_y-r); walls, the floor and set board cells all count as a hit.
module tetris_engine_collision_check #(
  parameter int unsigned BOARD_W  = 10,
  parameter int unsigned NUM_ROWS = 24,
  parameter int unsigned XW       = 5,
  parameter int unsigned YW       = 6
) (
  input  logic [NUM_ROWS-1:0][BOARD_W-1:0] board,
  input  logic [15:0]                      mask,
  input  logic [XW-1:0]                    pos_x,
  input  logic [YW-1:0]                    pos_y,
  output logic                             hit
);

  always_comb begin
    hit = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mask[r*4+c]) begin
          if (int'($signed(pos_x)) + c < 0 || int'($signed(pos_x)) + c >= int'(BOARD_W) ||
              int'($signed(pos_y)) - r < 0) begin
            hit = 1'b1;
          end
          for (int yy = 0; yy < int'(NUM_ROWS); yy++) begin
            for (int xx = 0; xx < int'(BOARD_W); xx++) begin
              if (board[yy][xx] && int'($signed(pos_x)) + c == xx &&
                  int'($signed(pos_y)) - r == yy) begin
                hit = 1'b1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/tetris_engine.sv
// Sequential Tetris core: one move per command through a shared collision check, then lock,
// bottom-up row clearing (one row per cycle) and spawn of the next piece.
module tetris_engine import tetris_engine_pkg::*; #(
  parameter int unsigned  BOARD_W = 10,
  parameter int unsigned  BOARD_H = 20,
  parameter int           SPAWN_X = 3,
  parameter int unsigned  XW      = 5,
  localparam int unsigned YW      = $clog2(BOARD_H + 4) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd,
  input  logic               grav_tick,
  input  logic [2:0]         piece_sel,
  input  logic [YW-2:0]      rd_row,
  output logic [BOARD_W-1:0] rd_data,
  output logic               clear_valid,
  output logic [2:0]         clear_cnt,
  output logic               game_over
);

  localparam int unsigned NR = BOARD_H + 4;
  localparam int unsigned RW = YW - 1;

  state_e                     state_q, state_d;
  logic [NR-1:0][BOARD_W-1:0] board_q, board_d, piece_plane;
  mask_t                      mask_q, mask_d, cand_mask_q, cand_mask_d, chk_mask, spawn_mask;
  logic [XW-1:0]              pos_x_q, pos_x_d, cand_x_q, cand_x_d, chk_x;
  logic [YW-1:0]              pos_y_q, pos_y_d, cand_y_q, cand_y_d, chk_y, pos_y_dn;
  logic                       cand_down_q, cand_down_d, grav_pend_q, grav_pend_d;
  logic [RW-1:0]              clr_y_q, clr_y_d;
  logic [2:0]                 clr_cnt_q, clr_cnt_d, clear_cnt_q, clear_cnt_d;
  logic                       clear_valid_q, clear_valid_d, alive_q;
  logic [BOARD_W-1:0]         rd_data_q, rd_data_d;
  logic                       hit, cmd_fire, top_out, row_full, show_piece;
  cmd_e                       cmd_c;

  assign cmd_c      = cmd_e'(cmd);
  assign spawn_mask = piece_mask(piece_sel);
  assign pos_y_dn   = pos_y_q - YW'(1);
  // alive_q keeps cmd_ready low while in reset and for the first cycle after release.
  assign cmd_ready  = alive_q && (state_q == StIdle || state_q == StOver ||
                                  (state_q == StReady && !grav_pend_q));
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign game_over  = (state_q == StOver);
  assign top_out    = |piece_plane[NR-1:BOARD_H];
  assign row_full   = &board_q[clr_y_q];
  assign show_piece = state_q inside {StReady, StCheck, StDrop};

  assign rd_data     = rd_data_q;
  assign clear_valid = clear_valid_q;
  assign clear_cnt   = clear_cnt_q;

  // Committed piece expanded onto the board grid; feeds lock, top-out and the read port.
  always_comb begin
    piece_plane = '0;
    for (int yy = 0; yy < int'(NR); yy++) begin
      for (int xx = 0; xx < int'(BOARD_W); xx++) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            if (mask_q[r*4+c] && int'($signed(pos_x_q)) + c == xx &&
                int'($signed(pos_y_q)) - r == yy) begin
              piece_plane[yy][xx] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    chk_mask = cand_mask_q;
    chk_x    = cand_x_q;
    chk_y    = cand_y_q;
    if (state_q == StDrop) begin
      chk_mask = mask_q;
      chk_x    = pos_x_q;
      chk_y    = pos_y_dn;
    end else if (state_q == StSpawn) begin
      chk_mask = spawn_mask;
      chk_x    = XW'(SPAWN_X);
      chk_y    = YW'(NR - 1);
    end
  end

  tetris_engine_collision_check #(
    .BOARD_W  (BOARD_W),
    .NUM_ROWS (NR),
    .XW       (XW),
    .YW       (YW)
  ) u_collision_check (
    .board (board_q),
    .mask  (chk_mask),
    .pos_x (chk_x),
    .pos_y (chk_y),
    .hit   (hit)
  );

  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    mask_d        = mask_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    cand_mask_d   = cand_mask_q;
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    cand_down_d   = cand_down_q;
    grav_pend_d   = grav_pend_q;
    clr_y_d       = clr_y_q;
    clr_cnt_d     = clr_cnt_q;
    clear_valid_d = 1'b0;
    clear_cnt_d   = clear_cnt_q;

    if (grav_tick && state_q != StReady) grav_pend_d = 1'b1;

    unique case (state_q)
      StIdle, StOver: begin
        if (cmd_fire && cmd_c == CmdStart) begin
          board_d = '0;
          state_d = StSpawn;
        end
      end
      StReady: begin
        cand_mask_d = mask_q;
        cand_x_d    = pos_x_q;
        cand_y_d    = pos_y_q;
        cand_down_d = 1'b0;
        if (grav_pend_q) begin
          cand_y_d    = pos_y_dn;
          cand_down_d = 1'b1;
          grav_pend_d = 1'b0;
          state_d     = StCheck;
        end else if (cmd_fire) begin
          grav_pend_d = grav_tick;
          state_d     = StCheck;
          unique case (cmd_c)
            CmdCw:    cand_mask_d = rot_cw(mask_q);
            CmdCcw:   cand_mask_d = rot_ccw(mask_q);
            CmdLeft:  cand_x_d = pos_x_q - XW'(1);
            CmdRight: cand_x_d = pos_x_q + XW'(1);
            CmdSoft: begin
              cand_y_d    = pos_y_dn;
              cand_down_d = 1'b1;
            end
            CmdHard:  state_d = StDrop;
            CmdStart: begin
              board_d = '0;
              state_d = StSpawn;
            end
            default:  state_d = StReady;
          endcase
        end else if (grav_tick) begin
          cand_y_d    = pos_y_dn;
          cand_down_d = 1'b1;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        state_d = StReady;
        if (!hit) begin
          mask_d  = cand_mask_q;
          pos_x_d = cand_x_q;
          pos_y_d = cand_y_q;
        end else if (cand_down_q) begin
          state_d = StLock;
        end
      end
      StDrop: begin
        if (!hit) pos_y_d = pos_y_dn;
        else      state_d = StLock;
      end
      StLock: begin
        board_d   = board_q | piece_plane;
        clr_y_d   = '0;
        clr_cnt_d = '0;
        state_d   = top_out ? StOver : StClear;
      end
      StClear: begin
        if (clr_y_q == RW'(BOARD_H)) begin
          clear_valid_d = (clr_cnt_q != 3'd0);
          if (clr_cnt_q != 3'd0) clear_cnt_d = clr_cnt_q;
          state_d = StSpawn;
        end else if (row_full) begin
          // Rows above collapse by one; the same y is re-tested next cycle.
          for (int yy = 0; yy < int'(NR) - 1; yy++) begin
            if (yy >= int'(clr_y_q)) board_d[yy] = board_q[yy+1];
          end
          board_d[NR-1] = '0;
          clr_cnt_d     = clr_cnt_q + 3'd1;
        end else begin
          clr_y_d = clr_y_q + RW'(1);
        end
      end
      StSpawn: begin
        mask_d  = spawn_mask;
        pos_x_d = XW'(SPAWN_X);
        pos_y_d = YW'(NR - 1);
        state_d = hit ? StOver : StReady;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_data_d = '0;
    if (int'(rd_row) < int'(NR)) begin
      rd_data_d = board_q[rd_row];
      if (show_piece) rd_data_d = rd_data_d | piece_plane[rd_row];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      board_q       <= '0;
      mask_q        <= '0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      cand_mask_q   <= '0;
      cand_x_q      <= '0;
      cand_y_q      <= '0;
      cand_down_q   <= 1'b0;
      grav_pend_q   <= 1'b0;
      clr_y_q       <= '0;
      clr_cnt_q     <= '0;
      clear_valid_q <= 1'b0;
      clear_cnt_q   <= '0;
      rd_data_q     <= '0;
      alive_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      board_q       <= board_d;
      mask_q        <= mask_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      cand_mask_q   <= cand_mask_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      cand_down_q   <= cand_down_d;
      grav_pend_q   <= grav_pend_d;
      clr_y_q       <= clr_y_d;
      clr_cnt_q     <= clr_cnt_d;
      clear_valid_q <= clear_valid_d;
      clear_cnt_q   <= clear_cnt_d;
      rd_data_q     <= rd_data_d;
      alive_q       <= 1'b1;
    end
  end

endmodule
